alu_issue_ctrl: RTL and testbench

//  Initiator side of the 64-bit ALU interface (in1/in2/alu_c -> result/zero).

---
 rtl/alu_issue_ctrl.sv | 136 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Request/response controller in front of a combinational 64-bit ALU.
// Decodes ALUOp/funct3/funct7[5], issues for one cycle, returns result/zero or an error.
module alu_issue_ctrl #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_aluop,
    input  logic [2:0]       req_funct3,
    input  logic             req_funct7_b5,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [3:0]       alu_c,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] in1_q, in1_d;
    logic [WIDTH-1:0] in2_q, in2_d;
    logic [3:0]       c_q, c_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             dec_legal;
    logic [3:0]       dec_c;

    always_comb begin
        dec_legal = 1'b1;
        dec_c     = 4'b0010;
        unique case (req_aluop)
            2'b00: dec_c = 4'b0010;
            2'b01: dec_c = 4'b0110;
            2'b10: begin
                unique case ({req_funct7_b5, req_funct3})
                    4'b0_000: dec_c = 4'b0010;
                    4'b1_000: dec_c = 4'b0110;
                    4'b0_111: dec_c = 4'b0000;
                    4'b0_110: dec_c = 4'b0001;
                    default:  dec_legal = 1'b0;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        in1_d    = in1_q;
        in2_d    = in2_q;
        c_d      = c_q;
        result_d = result_q;
        zero_d   = zero_q;
        err_d    = err_q;
        count_d  = count_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (dec_legal) begin
                        in1_d   = req_a;
                        in2_d   = req_b;
                        c_d     = dec_c;
                        state_d = StExec;
                    end else begin
                        // Illegal encodings never reach the ALU; its inputs keep their old values.
                        result_d = '0;
                        zero_d   = 1'b0;
                        err_d    = 1'b1;
                        state_d  = StResp;
                    end
                end
            end
            StExec: begin
                result_d = alu_result;
                zero_d   = alu_zero;
                err_d    = 1'b0;
                state_d  = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    count_d = count_q + CNT_W'(1);
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            in1_q    <= '0;
            in2_q    <= '0;
            c_q      <= 4'b0000;
            result_q <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            in1_q    <= in1_d;
            in2_q    <= in2_d;
            c_q      <= c_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
            count_q  <= count_d;
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign rsp_valid  = (state_q == StResp);
    assign alu_in1    = in1_q;
    assign alu_in2    = in2_q;
    assign alu_c      = c_q;
    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;
    assign rsp_err    = err_q;
    assign op_count   = count_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed cases with literal expectations, then random traffic
// checked every cycle against a transaction-level reference model.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [1:0]  req_aluop = 2'b00;
    logic [2:0]  req_funct3 = 3'b000;
    logic        req_funct7_b5 = 1'b0;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic        rsp_ready = 1'b1;

    logic        req_ready, rsp_valid, rsp_zero, rsp_err, alu_zero;
    logic [63:0] alu_in1, alu_in2, alu_result, rsp_result;
    logic [3:0]  alu_c;
    logic [15:0] op_count;

    logic        req_ready2, rsp_valid2, rsp_zero2, rsp_err2, alu_zero2;
    logic [63:0] alu_in1_2, alu_in2_2, alu_result2, rsp_result2;
    logic [3:0]  alu_c2;
    logic [1:0]  op_count2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [63:0] alu_fn(input logic [3:0] c, input logic [63:0] a,
                                           input logic [63:0] b);
        case (c)
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0000: return a & b;
            4'b0001: return a | b;
            default: return 64'd0;
        endcase
    endfunction

    // Stand-in ALUs for both instances
    assign alu_result  = alu_fn(alu_c, alu_in1, alu_in2);
    assign alu_zero    = (alu_result == 64'd0);
    assign alu_result2 = alu_fn(alu_c2, alu_in1_2, alu_in2_2);
    assign alu_zero2   = (alu_result2 == 64'd0);

    alu_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_aluop(req_aluop), .req_funct3(req_funct3), .req_funct7_b5(req_funct7_b5),
        .req_a(req_a), .req_b(req_b), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_c(alu_c),
        .alu_result(alu_result), .alu_zero(alu_zero), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .rsp_err(rsp_err), .op_count(op_count)
    );

    alu_issue_ctrl #(.WIDTH(64), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready2),
        .req_aluop(req_aluop), .req_funct3(req_funct3), .req_funct7_b5(req_funct7_b5),
        .req_a(req_a), .req_b(req_b), .alu_in1(alu_in1_2), .alu_in2(alu_in2_2),
        .alu_c(alu_c2), .alu_result(alu_result2), .alu_zero(alu_zero2),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_result(rsp_result2),
        .rsp_zero(rsp_zero2), .rsp_err(rsp_err2), .op_count(op_count2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // op: 0 illegal, 1 add, 2 sub, 3 and, 4 or
    function automatic int op_of(input logic [1:0] aluop, input logic [2:0] f3,
                                 input logic f7);
        if (aluop == 2'b00) return 1;
        if (aluop == 2'b01) return 2;
        if (aluop == 2'b11) return 0;
        if (f3 == 3'd0) return f7 ? 2 : 1;
        if (f7) return 0;
        if (f3 == 3'd7) return 3;
        if (f3 == 3'd6) return 4;
        return 0;
    endfunction

    function automatic logic [3:0] code_of(input int op);
        case (op)
            1: return 4'b0010;
            2: return 4'b0110;
            3: return 4'b0000;
            default: return 4'b0001;
        endcase
    endfunction

    bit          m_rsp_valid = 1'b0;
    int          m_wait = 0;
    int          m_cnt = 0;
    logic [63:0] m_in1 = '0, m_in2 = '0, m_res = '0, pend_res = '0;
    logic [3:0]  m_c = 4'b0000;
    bit          m_zero = 1'b0, m_err = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rsp_valid = 1'b0; m_wait = 0; m_cnt = 0;
            m_in1 = '0; m_in2 = '0; m_c = 4'b0000;
            m_res = '0; m_zero = 1'b0; m_err = 1'b0;
        end else if (m_rsp_valid) begin
            if (rsp_ready) begin
                m_rsp_valid = 1'b0;
                m_cnt++;
            end
        end else if (m_wait > 0) begin
            m_wait--;
            m_res = pend_res; m_zero = (pend_res == 64'd0); m_err = 1'b0;
            m_rsp_valid = 1'b1;
        end else if (req_valid) begin
            int op;
            op = op_of(req_aluop, req_funct3, req_funct7_b5);
            if (op == 0) begin
                m_res = '0; m_zero = 1'b0; m_err = 1'b1;
                m_rsp_valid = 1'b1;
            end else begin
                m_in1 = req_a; m_in2 = req_b; m_c = code_of(op);
                case (op)
                    1: pend_res = req_a + req_b;
                    2: pend_res = req_a - req_b;
                    3: pend_res = req_a & req_b;
                    default: pend_res = req_a | req_b;
                endcase
                m_wait = 1;
            end
        end
    end

    always @(negedge clk) begin
        check("req_ready", 64'(req_ready), 64'(!m_rsp_valid && m_wait == 0));
        check("rsp_valid", 64'(rsp_valid), 64'(m_rsp_valid));
        check("alu_in1", alu_in1, m_in1);
        check("alu_in2", alu_in2, m_in2);
        check("alu_c", 64'(alu_c), 64'(m_c));
        check("rsp_result", rsp_result, m_res);
        check("rsp_zero", 64'(rsp_zero), 64'(m_zero));
        check("rsp_err", 64'(rsp_err), 64'(m_err));
        check("op_count", 64'(op_count), 64'(m_cnt % 65536));
        check("op_count_w2", 64'(op_count2), 64'(m_cnt % 4));
    end

    // ---------------- directed helpers ----------------
    task automatic run_op(input string name, input logic [1:0] aluop, input logic [2:0] f3,
                          input logic f7, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_res, input logic exp_zero, input logic exp_err,
                          input logic [3:0] exp_c, input int exp_lat);
        int k;
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_aluop = aluop; req_funct3 = f3; req_funct7_b5 = f7;
        req_a = a; req_b = b;
        @(posedge clk); #1;
        req_valid = 1'b0;
        k = 0;
        @(negedge clk);
        while (!rsp_valid && k < 10) begin
            k++;
            @(negedge clk);
        end
        check({name, "_latency"}, 64'(k + 1), 64'(exp_lat));
        check({name, "_result"}, rsp_result, exp_res);
        check({name, "_zero"}, 64'(rsp_zero), 64'(exp_zero));
        check({name, "_err"}, 64'(rsp_err), 64'(exp_err));
        check({name, "_alu_c"}, 64'(alu_c), 64'(exp_c));
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_req_ready", 64'(req_ready), 64'd1);
        check("reset_op_count", 64'(op_count), 64'd0);
        check("reset_alu_c", 64'(alu_c), 64'd0);
        rst_n = 1'b1;

        run_op("t1_add", 2'b10, 3'b000, 1'b0, 64'd5, 64'd7, 64'd12, 1'b0, 1'b0, 4'b0010, 2);
        check("t1_op_count", 64'(op_count), 64'd1);
        run_op("t2_beq", 2'b01, 3'b000, 1'b0, 64'hDEAD, 64'hDEAD, 64'd0, 1'b1, 1'b0,
               4'b0110, 2);
        run_op("t3_and", 2'b10, 3'b111, 1'b0, 64'hF0F0, 64'h0FF0, 64'h00F0, 1'b0, 1'b0,
               4'b0000, 2);
        run_op("t3_or", 2'b10, 3'b110, 1'b0, 64'hF0F0, 64'h0FF0, 64'hFFF0, 1'b0, 1'b0,
               4'b0001, 2);
        run_op("t4_rsvd", 2'b11, 3'b000, 1'b0, 64'd9, 64'd9, 64'd0, 1'b0, 1'b1, 4'b0001, 1);
        run_op("t4_f3", 2'b10, 3'b001, 1'b0, 64'd3, 64'd3, 64'd0, 1'b0, 1'b1, 4'b0001, 1);
        check("t4_op_count", 64'(op_count), 64'd6);
        check("t4_alu_in1", alu_in1, 64'hF0F0);

        // Stalled response while a second request waits
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_aluop = 2'b00; req_funct3 = 3'b000; req_funct7_b5 = 1'b0;
        req_a = 64'd100; req_b = 64'd23;
        @(posedge clk); #1;
        req_aluop = 2'b01; req_a = 64'd50; req_b = 64'd8;
        repeat (5) begin
            @(negedge clk);
            check("t5_req_ready", 64'(req_ready), 64'd0);
        end
        check("t5_hold_result", rsp_result, 64'd123);
        check("t5_hold_valid", 64'(rsp_valid), 64'd1);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("t5_second_not_taken", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_second_result", rsp_result, 64'd42);
        @(posedge clk); #1;

        // Reset in the middle of EXEC
        req_valid = 1'b1; req_aluop = 2'b00; req_a = 64'd1; req_b = 64'd2;
        @(posedge clk); #1;
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t6_rsp_valid", 64'(rsp_valid), 64'd0);
        check("t6_op_count", 64'(op_count), 64'd0);
        check("t6_req_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++)
            run_op("t6_op", 2'b00, 3'b000, 1'b0, 64'(i), 64'd1, 64'(i + 1), 1'b0, 1'b0,
                   4'b0010, 2);
        check("t6_count16", 64'(op_count), 64'd5);
        check("t6_count2_wrap", 64'(op_count2), 64'd1);

        // Random traffic, all checking done by the model comparison
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 599) == 0) rst_n = 1'b0;
            else rst_n = 1'b1;
            rsp_ready = ($urandom_range(0, 9) < 7);
            req_valid = ($urandom_range(0, 9) < 6);
            req_aluop = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: req_funct3 = 3'($urandom_range(0, 7));
                1: req_funct3 = 3'b111;
                2: req_funct3 = 3'b110;
                default: req_funct3 = 3'b000;
            endcase
            req_funct7_b5 = ($urandom_range(0, 4) == 0);
            req_a = {$urandom, $urandom};
            req_b = ($urandom_range(0, 3) == 0) ? req_a : {$urandom, $urandom};
        end
        @(posedge clk); #1;
        rst_n = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
        repeat (5) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
